board_state_writer: RTL and testbench



---
 rtl/board_pkg.sv | 60 ++++++
 rtl/board_state_writer_if.sv | 24 ++
 rtl/board_state_writer_cell_index.sv | 16 +
 rtl/board_state_writer.sv | 160 ++++++++++++++++
 tb/tb_board_state_writer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared constants, codes and types for the board write path.
// The opening layout is colourless: 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king.
package board_pkg;

    localparam int CELL_W    = 3;
    localparam int NUM_CELLS = 64;
    localparam int BOARD_W   = NUM_CELLS * CELL_W;

    typedef logic [CELL_W-1:0] cell_t;

    localparam cell_t EMPTY  = 3'b000;
    localparam cell_t PAWN   = 3'b001;
    localparam cell_t KNIGHT = 3'b010;
    localparam cell_t BISHOP = 3'b011;
    localparam cell_t ROOK   = 3'b100;
    localparam cell_t QUEEN  = 3'b101;
    localparam cell_t KING   = 3'b110;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_EMPTY = 2'b10,
        ERR_SAME  = 2'b11
    } err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic [5:0] src_idx;
        logic [5:0] dst_idx;
        cell_t      moved;
        cell_t      captured;
    } hist_t;

    function automatic int cell_lsb(input logic [5:0] idx);
        return int'(idx) * CELL_W;
    endfunction

    function automatic logic [BOARD_W-1:0] opening_board();
        logic [BOARD_W-1:0] b;
        cell_t              back [8];
        back = '{ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK};
        b    = '0;
        for (int x = 0; x < 8; x++) begin
            b[x * CELL_W +: CELL_W]        = back[x];
            b[(8 + x) * CELL_W +: CELL_W]  = PAWN;
            b[(48 + x) * CELL_W +: CELL_W] = PAWN;
            b[(56 + x) * CELL_W +: CELL_W] = back[x];
        end
        return b;
    endfunction

    localparam logic [BOARD_W-1:0] BOARD_INIT = opening_board();

endpackage

// File: rtl/board_state_writer_if.sv
// Move request / completion bundle between move entry logic and the board writer.
interface board_state_writer_if;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] src_x;
    logic [3:0] src_y;
    logic [3:0] dst_x;
    logic [3:0] dst_y;
    logic       undo_req;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [2:0] captured;

    modport master (
        output move_valid, src_x, src_y, dst_x, dst_y, undo_req,
        input  move_ready, done, error, err_code, captured
    );

    modport slave (
        input  move_valid, src_x, src_y, dst_x, dst_y, undo_req,
        output move_ready, done, error, err_code, captured
    );
endinterface

// File: rtl/board_state_writer_cell_index.sv
// Maps a 1-based (x, y) coordinate to a 6-bit cell index plus an in-range flag.
module cell_index (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    output logic [5:0] o_idx,
    output logic       o_in_range
);
    logic [2:0] w_x0;
    logic [2:0] w_y0;

    // Only the low three bits of (coord-1) matter; out-of-range values are flagged separately.
    assign w_x0       = i_x[2:0] - 3'd1;
    assign w_y0       = i_y[2:0] - 3'd1;
    assign o_idx      = {w_y0, w_x0};
    assign o_in_range = (i_x >= 4'd1) && (i_x <= 4'd8) && (i_y >= 4'd1) && (i_y <= 4'd8);
endmodule

// File: rtl/board_state_writer.sv
// Write side of the 192-bit BoardState register: validates and executes one move at a time.
// Optional single-level undo is enabled by defining BOARD_UNDO_EN.
module board_state_writer
    import board_pkg::*;
#(
    parameter logic [BOARD_W-1:0] START_BOARD = BOARD_INIT
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    board_state_writer_if.slave  bus,
    output logic [7:0]           move_count,
    output logic [BOARD_W-1:0]   BoardState
);
    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_src_x, r_src_y, r_dst_x, r_dst_y;
    logic [BOARD_W-1:0] r_board;
    logic [7:0]         r_count;
    logic               r_error;
    err_t               r_err_code;
    cell_t              r_captured;

    logic [5:0]         w_src_idx, w_dst_idx;
    logic               w_src_ok, w_dst_ok;
    cell_t              w_src_cell, w_dst_cell;
    err_t               w_chk_err;
    logic               w_chk_fail;

`ifdef BOARD_UNDO_EN
    logic               r_is_undo;
    logic               r_hist_valid;
    hist_t              r_hist;
`else
    logic               w_unused_undo;
    assign w_unused_undo = bus.undo_req;
`endif

    cell_index u_src_index (.i_x(r_src_x), .i_y(r_src_y), .o_idx(w_src_idx), .o_in_range(w_src_ok));
    cell_index u_dst_index (.i_x(r_dst_x), .i_y(r_dst_y), .o_idx(w_dst_idx), .o_in_range(w_dst_ok));

    assign w_src_cell = r_board[cell_lsb(w_src_idx) +: CELL_W];
    assign w_dst_cell = r_board[cell_lsb(w_dst_idx) +: CELL_W];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_chk_err  = ERR_NONE;
        w_chk_fail = 1'b0;
        if (!(w_src_ok && w_dst_ok)) begin
            w_chk_err  = ERR_RANGE;
            w_chk_fail = 1'b1;
        end else if (w_src_idx == w_dst_idx) begin
            w_chk_err  = ERR_SAME;
            w_chk_fail = 1'b1;
        end else if (w_src_cell == EMPTY) begin
            w_chk_err  = ERR_EMPTY;
            w_chk_fail = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.move_valid) begin
                    w_next_state = CHECK;
`ifdef BOARD_UNDO_EN
                end else if (bus.undo_req) begin
                    w_next_state = WRITE;
`endif
                end
            end
            CHECK:   w_next_state = w_chk_fail ? DONE : WRITE;
            WRITE:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= IDLE;
            r_src_x    <= '0;
            r_src_y    <= '0;
            r_dst_x    <= '0;
            r_dst_y    <= '0;
            r_board    <= START_BOARD;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_captured <= EMPTY;
`ifdef BOARD_UNDO_EN
            r_is_undo    <= 1'b0;
            r_hist_valid <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (bus.move_valid) begin
                        r_src_x <= bus.src_x;
                        r_src_y <= bus.src_y;
                        r_dst_x <= bus.dst_x;
                        r_dst_y <= bus.dst_y;
`ifdef BOARD_UNDO_EN
                        r_is_undo <= 1'b0;
                    end else if (bus.undo_req) begin
                        r_is_undo <= 1'b1;
`endif
                    end
                end
                CHECK: begin
                    if (w_chk_fail) begin
                        r_error    <= 1'b1;
                        r_err_code <= w_chk_err;
                        r_captured <= EMPTY;
                    end
                end
                WRITE: begin
`ifdef BOARD_UNDO_EN
                    if (r_is_undo) begin
                        r_captured <= EMPTY;
                        r_err_code <= ERR_NONE;
                        r_error    <= !r_hist_valid;
                        if (r_hist_valid) begin
                            r_board[cell_lsb(r_hist.src_idx) +: CELL_W] <= r_hist.moved;
                            r_board[cell_lsb(r_hist.dst_idx) +: CELL_W] <= r_hist.captured;
                            r_hist_valid <= 1'b0;
                            r_count      <= r_count - 8'd1;
                        end
                    end else
`endif
                    begin
                        r_board[cell_lsb(w_dst_idx) +: CELL_W] <= w_src_cell;
                        r_board[cell_lsb(w_src_idx) +: CELL_W] <= EMPTY;
                        r_captured <= w_dst_cell;
                        r_count    <= r_count + 8'd1;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
`ifdef BOARD_UNDO_EN
                        // NOTE: only the valid bit is reset; the payload is never read while invalid.
                        r_hist       <= '{src_idx: w_src_idx, dst_idx: w_dst_idx,
                                          moved: w_src_cell, captured: w_dst_cell};
                        r_hist_valid <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.move_ready = (r_state == IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.error      = r_error;
    assign bus.err_code   = r_err_code;
    assign bus.captured   = r_captured;
    assign move_count     = r_count;
    assign BoardState     = r_board;
endmodule

// File: tb/tb_board_state_writer.sv
// Scoreboard bench for board_state_writer: directed plan plus randomized moves vs a cell-array model.
module tb_board_state_writer;
    import board_pkg::*;

    localparam logic [BOARD_W-1:0] TB_START = 192'd1 | (192'd7 << 27);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         move_count;
    logic [BOARD_W-1:0] board;

    board_state_writer_if bus ();

    board_state_writer #(.START_BOARD(TB_START)) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .bus        (bus),
        .move_count (move_count),
        .BoardState (board)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain array of cells plus a one-entry history.
    logic [2:0] m_board [64];
    int         m_count;
    logic       m_hv;
    int         m_hsrc, m_hdst;
    logic [2:0] m_hmov, m_hcap;

    function automatic logic [191:0] pack_model();
        logic [191:0] r;
        for (int i = 0; i < 64; i++) r[i*3 +: 3] = m_board[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_board[i] = TB_START[i*3 +: 3];
        m_count = 0;
        m_hv    = 1'b0;
    endtask

    typedef struct {
        logic         error;
        logic [1:0]   code;
        logic [2:0]   cap;
        logic         chk_cap;
        logic [191:0] brd;
        int           count;
        int           due;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending response (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("error", 192'(bus.error), 192'(mon_e.error));
                check("err_code", 192'(bus.err_code), 192'(mon_e.code));
                if (mon_e.chk_cap) check("captured", 192'(bus.captured), 192'(mon_e.cap));
                check("board", board, mon_e.brd);
                check("move_count", 192'(move_count), 192'(mon_e.count % 256));
                check("latency", 192'(cyc), 192'(mon_e.due));
            end
        end
    end

    function automatic exp_t model_move(input int sx, input int sy, input int dx, input int dy);
        exp_t e;
        int   si, di;
        e.error = 1'b1; e.cap = 3'b000; e.chk_cap = 1'b0; e.code = 2'b00;
        if (sx < 1 || sx > 8 || sy < 1 || sy > 8 || dx < 1 || dx > 8 || dy < 1 || dy > 8) begin
            e.code = 2'b01;
        end else begin
            si = (sy - 1) * 8 + (sx - 1);
            di = (dy - 1) * 8 + (dx - 1);
            if (si == di) e.code = 2'b11;
            else if (m_board[si] == 3'b000) e.code = 2'b10;
            else begin
                e.error   = 1'b0;
                e.chk_cap = 1'b1;
                e.cap     = m_board[di];
                m_hv = 1'b1; m_hsrc = si; m_hdst = di; m_hmov = m_board[si]; m_hcap = m_board[di];
                m_board[di] = m_board[si];
                m_board[si] = 3'b000;
                m_count = (m_count + 1) % 256;
            end
        end
        e.brd   = pack_model();
        e.count = m_count;
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.move_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 192'(bus.move_ready), 192'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue_move(input int sx, input int sy, input int dx, input int dy);
        exp_t e;
        int   acc;
        wait_ready();
        bus.src_x = 4'(sx); bus.src_y = 4'(sy);
        bus.dst_x = 4'(dx); bus.dst_y = 4'(dy);
        bus.move_valid = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        e = model_move(sx, sy, dx, dy);
        e.due = acc + (e.error ? 1 : 2);
        sb.push_back(e);
        @(negedge clk);
        bus.move_valid = 1'b0;
        check("ready_low_busy", 192'(bus.move_ready), 192'(0));
        wait_drain();
    endtask

`ifdef BOARD_UNDO_EN
    task automatic issue_undo();
        exp_t e;
        int   acc;
        wait_ready();
        bus.undo_req = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        e.chk_cap = 1'b0; e.cap = 3'b000; e.code = 2'b00;
        if (m_hv) begin
            e.error = 1'b0;
            m_board[m_hsrc] = m_hmov;
            m_board[m_hdst] = m_hcap;
            m_hv = 1'b0;
            m_count = (m_count + 255) % 256;
        end else begin
            e.error = 1'b1;
        end
        e.brd = pack_model();
        e.count = m_count;
        e.due = acc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.undo_req = 1'b0;
        wait_drain();
    endtask
`endif

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        bus.move_valid = 1'b0;
        bus.undo_req   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_board", board, TB_START);
        check("rst_count", 192'(move_count), 192'(0));
        check("rst_ready", 192'(bus.move_ready), 192'(1));
        check("rst_done", 192'(bus.done), 192'(0));
        rst = 1'b0;
        model_reset();
    endtask

    function automatic int rand_coord();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return 0;
        if (r == 1) return 9;
        if (r == 2) return 15;
        return int'($urandom_range(1, 8));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int sx, sy, dx, dy, s;
        int occ [$];
        bus.move_valid = 1'b0;
        bus.undo_req   = 1'b0;
        bus.src_x = '0; bus.src_y = '0; bus.dst_x = '0; bus.dst_y = '0;
        model_reset();

        reset_dut();

        issue_move(1, 1, 1, 3);
        check("plan1_idx16", 192'(board[48 +: 3]), 192'(3'b001));
        check("plan1_idx0", 192'(board[0 +: 3]), 192'(3'b000));
        issue_move(2, 2, 1, 3);
        check("plan2_idx16", 192'(board[48 +: 3]), 192'(3'b111));
        check("plan2_count", 192'(move_count), 192'(2));
        issue_move(0, 1, 1, 2);
        issue_move(4, 4, 4, 4);
        issue_move(5, 5, 6, 6);
        issue_move(9, 1, 1, 15);

        // Reset landing on the WRITE edge must discard the move entirely.
        reset_dut();
        wait_ready();
        bus.src_x = 4'd1; bus.src_y = 4'd1; bus.dst_x = 4'd8; bus.dst_y = 4'd8;
        bus.move_valid = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        bus.move_valid = 1'b0;
        while (cyc < acc + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_board", board, TB_START);
        check("midrst_count", 192'(move_count), 192'(0));
        check("midrst_ready", 192'(bus.move_ready), 192'(1));
        check("midrst_done", 192'(bus.done), 192'(0));
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);

`ifdef BOARD_UNDO_EN
        issue_move(1, 1, 2, 2);
        issue_undo();
        check("undo_idx0", 192'(board[0 +: 3]), 192'(3'b001));
        check("undo_idx9", 192'(board[27 +: 3]), 192'(3'b111));
        check("undo_count", 192'(move_count), 192'(0));
        issue_undo();
`else
        @(negedge clk);
        bus.undo_req = 1'b1;
        repeat (4) @(negedge clk);
        check("undo_ignored_ready", 192'(bus.move_ready), 192'(1));
        check("undo_ignored_board", board, TB_START);
        bus.undo_req = 1'b0;
`endif

        for (int i = 0; i < 60; i++) begin
            occ.delete();
            for (int c = 0; c < 64; c++) if (m_board[c] != 3'b000) occ.push_back(c);
`ifdef BOARD_UNDO_EN
            if ($urandom_range(0, 6) == 0) begin
                issue_undo();
                continue;
            end
`endif
            if (occ.size() > 0 && $urandom_range(0, 9) < 6) begin
                s  = occ[$urandom_range(0, occ.size() - 1)];
                sx = s % 8 + 1;
                sy = s / 8 + 1;
            end else begin
                sx = rand_coord();
                sy = rand_coord();
            end
            if ($urandom_range(0, 3) == 0 && occ.size() > 0) begin
                s  = occ[$urandom_range(0, occ.size() - 1)];
                dx = s % 8 + 1;
                dy = s / 8 + 1;
            end else begin
                dx = rand_coord();
                dy = rand_coord();
            end
            issue_move(sx, sy, dx, dy);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
